// File: rtl/fifo_queue.sv
// fifo_queue: single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
module fifo_queue #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DC = CW'(DEPTH);
  localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE = CW'(AE_LEVEL);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full         = count == DC;
  assign empty        = count == '0;
  assign almost_full  = count >= AF;
  assign almost_empty = count <= AE;
  // a full FIFO can still take a word when the oldest one leaves on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      end
      count     <= count + CW'(do_push) - CW'(do_pop);
      overflow  <= overflow | (push & ~do_push);
      underflow <= underflow | (pop & ~do_pop);
    end
  always_ff @(posedge clk)
    if (!clear && do_push) mem[wr_ptr] <= data_in;
endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue: directed checks of a DEPTH=4 and a DEPTH=3 instance against a queue model.
module tb_fifo_queue;
  logic clk = 0, rst = 1, clr4 = 0, clr3 = 0;
  logic push4 = 0, pop4 = 0, push3 = 0, pop3 = 0;
  logic [7:0] din4 = 0, din3 = 0, dout4, dout3;
  logic full4, empty4, af4, ae4, ov4, un4, full3, empty3, af3, ae3, ov3, un3;
  logic [2:0] cnt4;
  logic [1:0] cnt3;
  logic [7:0] q4 [$], q3 [$];
  logic [7:0] dm4 = 0, dm3 = 0;
  bit om4 = 0, um4 = 0, om3 = 0, um3 = 0;
  int tests = 0, fails = 0;

  fifo_queue #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .clear(clr4), .push(push4), .data_in(din4), .pop(pop4),
    .data_out(dout4), .full(full4), .empty(empty4), .almost_full(af4), .almost_empty(ae4),
    .count(cnt4), .overflow(ov4), .underflow(un4));
  fifo_queue #(.WIDTH(8), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .clear(clr3), .push(push3), .data_in(din3), .pop(pop3),
    .data_out(dout3), .full(full3), .empty(empty3), .almost_full(af3), .almost_empty(ae3),
    .count(cnt3), .overflow(ov3), .underflow(un3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit s, input bit ps, input logic [7:0] d, input bit pp);
    int sz, dep;
    bit pa, wa;
    sz  = s ? q3.size() : q4.size();
    dep = s ? 3 : 4;
    pa  = pp && sz > 0;
    wa  = ps && (sz < dep || pa);
    if (s) begin push3 = ps; din3 = d; pop3 = pp; end
    else begin push4 = ps; din4 = d; pop4 = pp; end
    @(posedge clk); #1;
    push4 = 0; pop4 = 0; push3 = 0; pop3 = 0;
    if (s) begin
      if (pa) dm3 = q3.pop_front();
      if (wa) q3.push_back(d);
      om3 |= ps && !wa; um3 |= pp && !pa;
      chk("dout3", dout3, dm3);
      chk("count3", cnt3, q3.size());
      chk("ovf3", ov3, om3);
      chk("unf3", un3, um3);
    end else begin
      if (pa) dm4 = q4.pop_front();
      if (wa) q4.push_back(d);
      om4 |= ps && !wa; um4 |= pp && !pa;
      chk("dout4", dout4, dm4);
      chk("count4", cnt4, q4.size());
      chk("ovf4", ov4, om4);
      chk("unf4", un4, um4);
    end
  endtask

  task automatic flags4(input string tag, input bit f, input bit e, input bit a_f, input bit a_e);
    chk({tag, ".full"}, full4, f);
    chk({tag, ".empty"}, empty4, e);
    chk({tag, ".af"}, af4, a_f);
    chk({tag, ".ae"}, ae4, a_e);
  endtask

  initial begin
    #12;
    chk("rst.count", cnt4, 0);
    chk("rst.dout", dout4, 0);
    chk("rst.ovf", ov4, 0);
    chk("rst.unf", un4, 0);
    flags4("rst", 0, 1, 0, 1);
    chk("rst3.count", cnt3, 0);
    rst = 0;
    @(posedge clk); #1;
    // ordering
    cyc(0, 1, 8'h11, 0); cyc(0, 1, 8'h22, 0); cyc(0, 1, 8'h33, 0);
    flags4("three", 0, 0, 1, 0);
    cyc(0, 1, 8'h44, 0);
    flags4("full", 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("order.last", dout4, 8'h44);
    flags4("drained", 0, 1, 0, 1);
    // simultaneous push/pop when full
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hA0 + 8'(i), 0);
    cyc(0, 1, 8'hB0, 1);
    chk("simul.dout", dout4, 8'hA0);
    chk("simul.count", cnt4, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("simul.last", dout4, 8'hB0);
    // overflow / underflow / clear
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hC0 + 8'(i), 0);
    cyc(0, 1, 8'h55, 0);
    chk("ovf.set", ov4, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("ovf.keep", dout4, 8'hC3);
    cyc(0, 0, 0, 1);
    chk("unf.set", un4, 1);
    chk("unf.dout", dout4, 8'hC3);
    cyc(0, 1, 8'h66, 1);
    chk("empty_pp.count", cnt4, 1);
    chk("empty_pp.dout", dout4, 8'hC3);
    clr4 = 1; push4 = 1; din4 = 8'h99;
    @(posedge clk); #1;
    clr4 = 0; push4 = 0;
    q4.delete(); om4 = 0; um4 = 0;
    chk("clr.count", cnt4, 0);
    chk("clr.ovf", ov4, 0);
    chk("clr.unf", un4, 0);
    chk("clr.dout", dout4, 8'hC3);
    // async reset mid-operation
    cyc(0, 1, 8'h01, 0); cyc(0, 1, 8'h02, 0);
    #2 rst = 1; #1;
    q4.delete(); q3.delete(); dm4 = 0; dm3 = 0; om4 = 0; um4 = 0;
    chk("arst.count", cnt4, 0);
    chk("arst.empty", empty4, 1);
    chk("arst.dout", dout4, 0);
    #1 rst = 0;
    @(posedge clk); #1;
    cyc(0, 1, 8'h77, 0);
    cyc(0, 0, 0, 1);
    chk("arst.after", dout4, 8'h77);
    // pointer wrap on DEPTH=3
    cyc(1, 1, 8'hF1, 0); cyc(1, 1, 8'hF2, 0);
    chk("wrap.af", af3, 1);
    chk("wrap.ae", ae3, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 1, 8'(i), 1);
      chk("wrap.cnt", cnt3, 2);
    end
    chk("wrap.dout", dout3, 8'h08);
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    chk("wrap.last", dout3, 8'h0A);
    chk("wrap.empty", empty3, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
